ysyx_lsu_axi: RTL and testbench

Parametrised load/store unit for the ysyx core. It takes one memory request at a time from the EXU over a valid/ready handshake and runs it as an AXI4-Lite master transaction. It aligns store data and strobes into byte lanes, and extracts and sign/zero-extends load data. It flags misaligned, bus-error and timeout faults, then holds the result until the WBU accepts it. It sits between the EXU and the data-side AXI crossbar, with a single transaction outstanding.

---
 rtl/ysyx_lsu_pkg.sv | 22 ++
 rtl/ysyx_lsu_axi_if.sv | 52 +++++
 rtl/ysyx_lsu_axi_lane.sv | 61 ++++++
 rtl/ysyx_lsu_axi.sv | 192 +++++++++++++++++++
 tb/tb_ysyx_lsu_axi.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_lsu_pkg.sv
// ysyx LSU shared definitions: FSM states, fault codes, access sizes.
// No ports; imported by the interface, lane helper and LSU top.
package ysyx_lsu_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_BUS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

endpackage

// File: rtl/ysyx_lsu_axi_if.sv
// AXI4-Lite data-side bus bundle between the LSU (master) and crossbar.
// Ports: AR/R/AW/W/B channels; master and slave modports.
interface ysyx_lsu_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/ysyx_lsu_axi_lane.sv
// Byte-lane steering: store data/strobe shift, load extract and extend.
// Ports: size, unsigned, lane offset, store data in/out, strobe, load raw/out.
module ysyx_lsu_lane
  import ysyx_lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [DATA_W-1:0] st_wdata,
  output logic [STRB_W-1:0] st_wstrb,
  output logic [DATA_W-1:0] ld_data
);

  logic [OFF_W+2:0]  sh;
  logic [STRB_W-1:0] strb_m;
  logic [DATA_W-1:0] keep;
  logic [DATA_W-1:0] raw;
  logic              sbit;

  assign sh = {off, 3'b000};

  always_comb begin
    strb_m = '0;
    keep   = '0;
    sbit   = 1'b0;
    raw    = ld_raw >> sh;
    unique case (size)
      SZ_B: begin
        strb_m = STRB_W'(8'h01);
        keep   = DATA_W'(64'hFF);
        sbit   = raw[7];
      end
      SZ_H: begin
        strb_m = STRB_W'(8'h03);
        keep   = DATA_W'(64'hFFFF);
        sbit   = raw[15];
      end
      SZ_W: begin
        strb_m = STRB_W'(8'h0F);
        keep   = DATA_W'(64'hFFFF_FFFF);
        sbit   = raw[31];
      end
      SZ_D: begin
        strb_m = '1;
        keep   = '1;
        sbit   = raw[DATA_W-1];
      end
    endcase
    st_wstrb = strb_m << off;
    st_wdata = st_data << sh;
    // Sign fill: everything above the access width copies its top bit.
    ld_data  = (raw & keep) | ((!uns && sbit) ? ~keep : '0);
  end

endmodule

// File: rtl/ysyx_lsu_axi.sv
// ysyx load/store unit: one EXU request at a time run as AXI4-Lite master.
// Ports: clk/rst, req_* from EXU, resp_* to WBU, axi master bundle.
module ysyx_lsu_axi
  import ysyx_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  ysyx_lsu_axi_if.master    axi
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int OFF_W    = $clog2(STRB_W);
  localparam bit TMO_EN   = (TIMEOUT_CYC > 0);
  localparam int CNT_W    = TMO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TMO_LAST = TMO_EN ? TIMEOUT_CYC - 1 : 0;

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              mis;
  logic              busy;
  logic              tmo_hit;
  logic [DATA_W-1:0] st_wdata;
  logic [STRB_W-1:0] st_wstrb;
  logic [DATA_W-1:0] ld_data;

  ysyx_lsu_lane #(
    .DATA_W (DATA_W)
  ) u_lane (
    .size     (size_q),
    .uns      (uns_q),
    .off      (addr_q[OFF_W-1:0]),
    .st_data  (wdata_q),
    .ld_raw   (axi.rdata),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_data  (ld_data)
  );

  // A dword on a 32-bit bus is treated as a misaligned access.
  always_comb begin
    mis = 1'b0;
    unique case (req_size)
      SZ_B: mis = 1'b0;
      SZ_H: mis = req_addr[0];
      SZ_W: mis = |req_addr[1:0];
      SZ_D: mis = (DATA_W == 32) || (|req_addr[2:0]);
    endcase
  end

  assign busy    = state_q inside {S_RD_ADDR, S_RD_DATA,
                                   S_WR_REQ, S_WR_RESP};
  assign tmo_hit = TMO_EN && (cnt_q == CNT_W'(TMO_LAST));

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          size_d    = req_size;
          uns_d     = req_unsigned;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          err_d     = ERR_OK;
          if (mis) begin
            err_d   = ERR_MISALIGN;
            state_d = S_RESP;
          end else begin
            state_d = req_we ? S_WR_REQ : S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        if (axi.arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (axi.rvalid) begin
          state_d = S_RESP;
          if (axi.rresp != 2'b00) err_d = ERR_BUS;
          else rdata_d = ld_data;
        end
      end
      S_WR_REQ: begin
        aw_done_d = aw_done_q | axi.awready;
        w_done_d  = w_done_q | axi.wready;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (axi.bvalid) begin
          state_d = S_RESP;
          if (axi.bresp != 2'b00) err_d = ERR_BUS;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A transaction finishing on the expiry cycle keeps its real result.
    if (TMO_EN && busy) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (tmo_hit && state_d != S_RESP) begin
        state_d = S_RESP;
        err_d   = ERR_TIMEOUT;
        rdata_d = '0;
      end
    end
    if (state_d == S_IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= ERR_OK;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

  assign axi.araddr  = addr_q;
  assign axi.arvalid = (state_q == S_RD_ADDR);
  assign axi.rready  = (state_q == S_RD_DATA);
  assign axi.awaddr  = addr_q;
  assign axi.awvalid = (state_q == S_WR_REQ) && !aw_done_q;
  assign axi.wvalid  = (state_q == S_WR_REQ) && !w_done_q;
  assign axi.wdata   = st_wdata;
  assign axi.wstrb   = st_wstrb;
  assign axi.bready  = (state_q == S_WR_RESP);

endmodule

// File: tb/tb_ysyx_lsu_axi.sv
// Scoreboard bench for ysyx_lsu_axi: 32-bit, 32-bit with timeout, 64-bit.
// Directed requests push expected responses; a monitor pops on resp handshakes.
module tb_ysyx_lsu_axi;
  import ysyx_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst_c;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int ar_cnt_a = 0;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  e;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t ea, eb, ec;

  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
  logic        a_resp_valid, a_resp_ready;
  logic [1:0]  a_req_size, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic        b_resp_valid, b_resp_ready;
  logic [1:0]  b_req_size, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

  logic        c_req_valid, c_req_ready, c_req_we, c_req_unsigned;
  logic        c_resp_valid, c_resp_ready;
  logic [1:0]  c_req_size, c_resp_err;
  logic [31:0] c_req_addr;
  logic [63:0] c_req_wdata, c_resp_rdata;

  ysyx_lsu_axi_if #(.ADDR_W(32), .DATA_W(32)) ax_a ();
  ysyx_lsu_axi_if #(.ADDR_W(32), .DATA_W(32)) ax_b ();
  ysyx_lsu_axi_if #(.ADDR_W(32), .DATA_W(64)) ax_c ();

  ysyx_lsu_axi #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(0)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_size(a_req_size),
    .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .axi(ax_a)
  );

  ysyx_lsu_axi #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_size(b_req_size),
    .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .axi(ax_b)
  );

  ysyx_lsu_axi #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(0)) dut_c (
    .clk(clk), .rst(rst_c),
    .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_we(c_req_we), .req_size(c_req_size),
    .req_unsigned(c_req_unsigned), .req_addr(c_req_addr),
    .req_wdata(c_req_wdata),
    .resp_valid(c_resp_valid), .resp_ready(c_resp_ready),
    .resp_rdata(c_resp_rdata), .resp_err(c_resp_err),
    .axi(ax_c)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rv(input int d);
    case (d)
      0:       return a_resp_valid;
      1:       return b_resp_valid;
      default: return c_resp_valid;
    endcase
  endfunction

  task automatic issue(input int d, input logic we, input logic [1:0] sz,
                       input logic un, input logic [31:0] ad,
                       input logic [63:0] wd);
    case (d)
      0: begin
        a_req_we = we; a_req_size = sz; a_req_unsigned = un;
        a_req_addr = ad; a_req_wdata = wd[31:0]; a_req_valid = 1'b1;
      end
      1: begin
        b_req_we = we; b_req_size = sz; b_req_unsigned = un;
        b_req_addr = ad; b_req_wdata = wd[31:0]; b_req_valid = 1'b1;
      end
      default: begin
        c_req_we = we; c_req_size = sz; c_req_unsigned = un;
        c_req_addr = ad; c_req_wdata = wd; c_req_valid = 1'b1;
      end
    endcase
    tick;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    c_req_valid = 1'b0;
  endtask

  // Called on cycle 1 after accept; counts cycles until resp_valid.
  task automatic wait_rv(input int d, input int exp_c, input string nm);
    int c = 1;
    while (!rv(d) && c < 40) begin
      tick;
      c++;
    end
    chk(nm, 64'(c), 64'(exp_c));
  endtask

  always @(negedge clk) begin
    if (ax_a.arvalid) ar_cnt_a++;
    if (a_resp_valid && a_resp_ready) begin
      if (q_a.size() == 0) begin
        n_chk++;
        $display("FAIL a_unexpected_resp: got resp, expected none");
      end else begin
        ea = q_a.pop_front();
        chk("a_rdata", 64'(a_resp_rdata), ea.d);
        chk("a_err", 64'(a_resp_err), 64'(ea.e));
      end
    end
    if (b_resp_valid && b_resp_ready) begin
      if (q_b.size() == 0) begin
        n_chk++;
        $display("FAIL b_unexpected_resp: got resp, expected none");
      end else begin
        eb = q_b.pop_front();
        chk("b_rdata", 64'(b_resp_rdata), eb.d);
        chk("b_err", 64'(b_resp_err), 64'(eb.e));
      end
    end
    if (c_resp_valid && c_resp_ready) begin
      if (q_c.size() == 0) begin
        n_chk++;
        $display("FAIL c_unexpected_resp: got resp, expected none");
      end else begin
        ec = q_c.pop_front();
        chk("c_rdata", c_resp_rdata, ec.d);
        chk("c_err", 64'(c_resp_err), 64'(ec.e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    int ar0;
    rst = 1'b1;
    rst_c = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_size = 0; a_req_unsigned = 0;
    a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 1;
    b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_unsigned = 0;
    b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 1;
    c_req_valid = 0; c_req_we = 0; c_req_size = 0; c_req_unsigned = 0;
    c_req_addr = 0; c_req_wdata = 0; c_resp_ready = 1;
    ax_a.arready = 0; ax_a.rdata = 0; ax_a.rresp = 0; ax_a.rvalid = 0;
    ax_a.awready = 0; ax_a.wready = 0; ax_a.bresp = 0; ax_a.bvalid = 0;
    ax_b.arready = 0; ax_b.rdata = 0; ax_b.rresp = 0; ax_b.rvalid = 0;
    ax_b.awready = 0; ax_b.wready = 0; ax_b.bresp = 0; ax_b.bvalid = 0;
    ax_c.arready = 0; ax_c.rdata = 0; ax_c.rresp = 0; ax_c.rvalid = 0;
    ax_c.awready = 0; ax_c.wready = 0; ax_c.bresp = 0; ax_c.bvalid = 0;
    repeat (3) tick;
    rst = 1'b0;
    rst_c = 1'b0;

    chk("rst_req_ready", 64'(a_req_ready), 64'(1));
    chk("rst_valids", 64'({ax_a.arvalid, ax_a.rready, ax_a.awvalid,
        ax_a.wvalid, ax_a.bready, a_resp_valid}), 64'(0));
    chk("rst_rdata", 64'(a_resp_rdata), 64'(0));
    chk("rst_err", 64'(a_resp_err), 64'(0));

    // Signed byte load from the top lane.
    ax_a.arready = 1; ax_a.rvalid = 1; ax_a.rdata = 32'h80FF_FF12;
    q_a.push_back(exp_t'{64'hFFFF_FFFF_FFFF_FF80 & 64'hFFFF_FFFF, ERR_OK});
    issue(0, 0, SZ_B, 0, 32'h8000_0003, 0);
    chk("ld_b_arvalid", 64'(ax_a.arvalid), 64'(1));
    chk("ld_b_araddr", 64'(ax_a.araddr), 64'h8000_0003);
    wait_rv(0, 3, "ld_b_latency");
    tick;
    ax_a.arready = 0; ax_a.rvalid = 0;

    // Half store, awready late by three cycles, wready immediate.
    ax_a.wready = 1;
    q_a.push_back(exp_t'{64'h0, ERR_OK});
    issue(0, 1, SZ_H, 0, 32'h8000_0002, 64'h0000_ABCD);
    chk("st_h_awvalid_c1", 64'(ax_a.awvalid), 64'(1));
    chk("st_h_wvalid_c1", 64'(ax_a.wvalid), 64'(1));
    chk("st_h_wdata", 64'(ax_a.wdata), 64'hABCD_0000);
    chk("st_h_wstrb", 64'(ax_a.wstrb), 64'hC);
    chk("st_h_awaddr", 64'(ax_a.awaddr), 64'h8000_0002);
    tick;
    chk("st_h_wvalid_c2", 64'(ax_a.wvalid), 64'(0));
    chk("st_h_awvalid_c2", 64'(ax_a.awvalid), 64'(1));
    tick;
    chk("st_h_awvalid_c3", 64'(ax_a.awvalid), 64'(1));
    tick;
    ax_a.awready = 1;
    chk("st_h_awvalid_c4", 64'(ax_a.awvalid), 64'(1));
    tick;
    ax_a.awready = 0;
    chk("st_h_awvalid_c5", 64'(ax_a.awvalid), 64'(0));
    chk("st_h_bready_c5", 64'(ax_a.bready), 64'(1));
    ax_a.bvalid = 1; ax_a.bresp = 0;
    tick;
    ax_a.bvalid = 0; ax_a.wready = 0;
    chk("st_h_resp_c6", 64'(a_resp_valid), 64'(1));
    tick;

    // Misaligned word and illegal dword: no AR traffic.
    ar0 = ar_cnt_a;
    q_a.push_back(exp_t'{64'h0, ERR_MISALIGN});
    issue(0, 0, SZ_W, 0, 32'h8000_0001, 0);
    wait_rv(0, 1, "mis_w_latency");
    tick;
    q_a.push_back(exp_t'{64'h0, ERR_MISALIGN});
    issue(0, 0, SZ_D, 0, 32'h8000_0000, 0);
    wait_rv(0, 1, "mis_d_latency");
    tick;
    chk("mis_no_arvalid", 64'(ar_cnt_a - ar0), 64'(0));

    // Bus error on read, response held while WBU stalls.
    ax_a.arready = 1; ax_a.rvalid = 1; ax_a.rresp = 2'b10;
    ax_a.rdata = 32'hDEAD_BEEF;
    a_resp_ready = 0;
    q_a.push_back(exp_t'{64'h0, ERR_BUS});
    issue(0, 0, SZ_W, 0, 32'h8000_0004, 0);
    wait_rv(0, 3, "bus_latency");
    for (int i = 0; i < 5; i++) begin
      chk("bus_hold_valid", 64'(a_resp_valid), 64'(1));
      chk("bus_hold_err", 64'(a_resp_err), 64'(ERR_BUS));
      chk("bus_hold_rdata", 64'(a_resp_rdata), 64'(0));
      chk("bus_hold_req_ready", 64'(a_req_ready), 64'(0));
      tick;
    end
    a_resp_ready = 1;
    tick;
    chk("bus_back_idle", 64'(a_req_ready), 64'(1));
    ax_a.arready = 0; ax_a.rvalid = 0; ax_a.rresp = 0;

    // Timeout on a stuck AR channel, then a normal load.
    q_b.push_back(exp_t'{64'h0, ERR_TIMEOUT});
    issue(1, 0, SZ_W, 0, 32'h0000_0200, 0);
    wait_rv(1, 5, "tmo_latency");
    chk("tmo_arvalid_low", 64'(ax_b.arvalid), 64'(0));
    tick;
    chk("tmo_arvalid_idle", 64'(ax_b.arvalid), 64'(0));
    ax_b.arready = 1; ax_b.rvalid = 1; ax_b.rdata = 32'h1234_5678;
    q_b.push_back(exp_t'{64'h1234_5678, ERR_OK});
    issue(1, 0, SZ_W, 0, 32'h0000_0100, 0);
    wait_rv(1, 3, "tmo_next_latency");
    tick;
    ax_b.arready = 0; ax_b.rvalid = 0;

    // 64-bit bus: dword load, lane loads, reset during WR_RESP.
    ax_c.arready = 1; ax_c.rvalid = 1;
    ax_c.rdata = 64'h8000_0000_0000_0001;
    q_c.push_back(exp_t'{64'h8000_0000_0000_0001, ERR_OK});
    issue(2, 0, SZ_D, 0, 32'h0000_0010, 0);
    wait_rv(2, 3, "ld_d_latency");
    tick;
    ax_c.rdata = 64'hAB00_0000_0000_0000;
    q_c.push_back(exp_t'{64'h0000_0000_0000_00AB, ERR_OK});
    issue(2, 0, SZ_B, 1, 32'h0000_0017, 0);
    wait_rv(2, 3, "ld_bu64_latency");
    tick;
    ax_c.arready = 0; ax_c.rvalid = 0;

    ax_c.awready = 1; ax_c.wready = 1;
    issue(2, 1, SZ_W, 0, 32'h0000_0014, 64'h1122_3344);
    chk("st_w64_wdata", ax_c.wdata, 64'h1122_3344_0000_0000);
    chk("st_w64_wstrb", 64'(ax_c.wstrb), 64'hF0);
    tick;
    chk("st_w64_bready", 64'(ax_c.bready), 64'(1));
    rst_c = 1'b1;
    tick;
    rst_c = 1'b0;
    chk("rst_mid_req_ready", 64'(c_req_ready), 64'(1));
    chk("rst_mid_valids", 64'({ax_c.arvalid, ax_c.rready, ax_c.awvalid,
        ax_c.wvalid, ax_c.bready, c_resp_valid}), 64'(0));
    ax_c.awready = 0; ax_c.wready = 0;

    ax_c.arready = 1; ax_c.rvalid = 1;
    ax_c.rdata = 64'h0000_AB00_0000_0000;
    q_c.push_back(exp_t'{64'hFFFF_FFFF_FFFF_AB00, ERR_OK});
    issue(2, 0, SZ_H, 0, 32'h0000_0014, 0);
    wait_rv(2, 3, "ld_h64_latency");
    tick;
    ax_c.arready = 0; ax_c.rvalid = 0;

    repeat (2) tick;
    chk("q_a_drained", 64'(q_a.size()), 64'(0));
    chk("q_b_drained", 64'(q_b.size()), 64'(0));
    chk("q_c_drained", 64'(q_c.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
